// File: rtl/multdiv_pkg.sv
// Shared types and constants for the mult/div issue controller.
// Holds the FSM state encoding, datapath widths, the default result
// timeout and the packed payloads for a latched operation and a writeback.
package multdiv_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned TAG_W           = 5;
  localparam int unsigned CNT_W           = 7;
  localparam int unsigned TIMEOUT_DEFAULT = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } md_state_e;

  // Operation captured from the pipeline when it is accepted.
  typedef struct packed {
    logic              is_div;
    logic [TAG_W-1:0]  rd;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
  } md_op_t;

  // Writeback payload captured from the unit, or built on timeout.
  typedef struct packed {
    logic [TAG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
    logic              exception;
  } md_wb_t;

endpackage

// File: rtl/multdiv_issue_ctrl_if.sv
// Bundle of pipeline-side and unit-side signals of the mult/div issue controller.
//   pipeline -> ctrl : in_valid, in_is_div, in_opA, in_opB, in_rd, flush
//   ctrl -> unit     : ctrl_MULT, ctrl_DIV, data_operandA, data_operandB
//   unit -> ctrl     : data_result, data_exception, data_resultRDY
//   ctrl -> pipeline : stall, wb_valid, wb_rd, wb_data, wb_exception
// master = surrounding pipeline/unit environment, slave = the controller.
interface multdiv_issue_ctrl_if;
  import multdiv_pkg::*;

  logic              in_valid;
  logic              in_is_div;
  logic [DATA_W-1:0] in_opA;
  logic [DATA_W-1:0] in_opB;
  logic [TAG_W-1:0]  in_rd;
  logic              flush;
  logic              ctrl_MULT;
  logic              ctrl_DIV;
  logic [DATA_W-1:0] data_operandA;
  logic [DATA_W-1:0] data_operandB;
  logic [DATA_W-1:0] data_result;
  logic              data_exception;
  logic              data_resultRDY;
  logic              stall;
  logic              wb_valid;
  logic [TAG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              wb_exception;

  modport master (
    output in_valid, in_is_div, in_opA, in_opB, in_rd, flush,
           data_result, data_exception, data_resultRDY,
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
           stall, wb_valid, wb_rd, wb_data, wb_exception
  );

  modport slave (
    input  in_valid, in_is_div, in_opA, in_opB, in_rd, flush,
           data_result, data_exception, data_resultRDY,
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
           stall, wb_valid, wb_rd, wb_data, wb_exception
  );

endinterface

// File: rtl/md_timeout_counter.sv
// Saturating wait-cycle counter for the mult/div issue controller.
//   clock, reset  : clock, asynchronous active-high reset
//   clear         : synchronous clear to zero (priority over enable)
//   enable        : count up by one, holding at all-ones
//   count         : current count
//   terminal_c    : count has reached LIMIT-1, so this cycle completes LIMIT counts
module md_timeout_counter
  import multdiv_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             terminal_c
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(LIMIT - 1);

  // Count register; saturates instead of wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign terminal_c = (count == LAST);

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Issue controller between the pipeline and a multi-cycle mult/div unit.
// Accepts one operation, pulses the unit start, waits for the result (with a
// timeout), and returns a one-cycle writeback while stalling the pipeline.
//   clock, reset : clock, asynchronous active-high reset
//   bus          : multdiv_issue_ctrl_if.slave (pipeline, unit, writeback)
module multdiv_issue_ctrl
  import multdiv_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input logic                clock,
  input logic                reset,
  multdiv_issue_ctrl_if.slave bus
);

  md_state_e        state, state_nxt;
  md_op_t           op_q;
  md_wb_t           wb_q;
  logic             accept_c, capture_c, timeout_c;
  logic             cnt_clear_c, cnt_en_c, terminal_c;
  logic [CNT_W-1:0] count;

  md_timeout_counter #(.LIMIT(TIMEOUT)) u_timeout (
    .clock      (clock),
    .reset      (reset),
    .clear      (cnt_clear_c),
    .enable     (cnt_en_c),
    .count      (count),
    .terminal_c (terminal_c)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, datapath enables and stall.
  always_comb begin
    state_nxt   = state;
    accept_c    = 1'b0;
    capture_c   = 1'b0;
    timeout_c   = 1'b0;
    cnt_clear_c = 1'b0;
    cnt_en_c    = 1'b0;
    bus.stall   = 1'b0;
    unique case (state)
      IDLE: begin
        // Stall goes up in the acceptance cycle itself.
        if (bus.in_valid && !bus.flush && !reset) begin
          accept_c  = 1'b1;
          bus.stall = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        bus.stall   = 1'b1;
        cnt_clear_c = 1'b1;
        state_nxt   = bus.flush ? IDLE : WAIT;
      end
      WAIT: begin
        bus.stall = 1'b1;
        cnt_en_c  = 1'b1;
        if (bus.flush) begin
          state_nxt = IDLE;
        end else if (bus.data_resultRDY && (count != '0)) begin
          // count==0 marks the first WAIT cycle, where a leftover strobe is ignored.
          capture_c = 1'b1;
          state_nxt = DONE;
        end else if (terminal_c) begin
          timeout_c = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand latch and writeback capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q <= '0;
      wb_q <= '0;
    end else begin
      if (accept_c) begin
        op_q <= '{is_div: bus.in_is_div, rd: bus.in_rd, op_a: bus.in_opA, op_b: bus.in_opB};
      end
      if (capture_c) begin
        wb_q <= '{rd: op_q.rd, data: bus.data_result, exception: bus.data_exception};
      end else if (timeout_c) begin
        wb_q <= '{rd: op_q.rd, data: '0, exception: 1'b1};
      end
    end
  end

  assign bus.ctrl_MULT     = (state == ISSUE) && !op_q.is_div;
  assign bus.ctrl_DIV      = (state == ISSUE) && op_q.is_div;
  assign bus.data_operandA = op_q.op_a;
  assign bus.data_operandB = op_q.op_b;
  // A flush arriving in the writeback cycle still cancels the writeback.
  assign bus.wb_valid      = (state == DONE) && !bus.flush;
  assign bus.wb_rd         = wb_q.rd;
  assign bus.wb_data       = wb_q.data;
  assign bus.wb_exception  = wb_q.exception;

endmodule

// File: doc/multdiv_issue_ctrl.md
MULTDIV_ISSUE_CTRL -- requirements
Module: multdiv_issue_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, max cycles waited for data_resultRDY after issue.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  pipeline presents a mult/div instruction this cycle.
REQ-005 SHALL have port in_is_div  input  1  1 = divide, 0 = multiply.
REQ-006 SHALL have port in_opA  input  32  dividend / multiplicand.
REQ-007 SHALL have port in_opB  input  32  divisor / multiplier.
REQ-008 SHALL have port in_rd  input  5  destination register tag.
REQ-009 SHALL have port flush  input  1  kill any in-flight operation.
REQ-010 SHALL have port ctrl_MULT  output  1  one-cycle start pulse to multdiv unit.
REQ-011 SHALL have port ctrl_DIV  output  1  one-cycle start pulse to multdiv unit.
REQ-012 SHALL have port data_operandA  output  32  latched opA, stable from issue until DONE.
REQ-013 SHALL have port data_operandB  output  32  latched opB, stable from issue until DONE.
REQ-014 SHALL have port data_result  input  32  result from multdiv unit.
REQ-015 SHALL have port data_exception  input  1  overflow / divide-by-zero from multdiv unit.
REQ-016 SHALL have port data_resultRDY  input  1  result-ready strobe from multdiv unit.
REQ-017 SHALL have port stall  output  1  holds upstream pipeline while an operation is outstanding.
REQ-018 SHALL have port wb_valid  output  1  one-cycle writeback strobe.
REQ-019 SHALL have port wb_rd  output  5  writeback register tag.
REQ-020 SHALL have port wb_data  output  32  writeback value.
REQ-021 SHALL have port wb_exception  output  1  unit exception or timeout.

Function
REQ-022 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-023 IDLE: on in_valid & ~flush, SHALL latch opA, opB, rd, is_div and go to ISSUE; stall=1 from this same cycle (combinational on in_valid).
REQ-024 ISSUE: SHALL assert exactly one of ctrl_MULT/ctrl_DIV for exactly one cycle per is_div, clear timeout counter, go to WAIT.
REQ-025 WAIT: SHALL ignore data_resultRDY in the first WAIT cycle (stale strobe guard); from the second WAIT cycle, data_resultRDY=1 SHALL capture data_result and data_exception and go to DONE.
REQ-026 WAIT: timeout counter SHALL increment each cycle; on reaching TIMEOUT without RDY, SHALL go to DONE with wb_data=0, wb_exception=1.
REQ-027 DONE: SHALL assert wb_valid for one cycle with captured rd/data/exception, deassert stall, return to IDLE.
REQ-028 stall SHALL be 1 in ISSUE and WAIT, 0 in DONE and in IDLE absent in_valid.
REQ-029 flush in ISSUE or WAIT SHALL return to IDLE next cycle, suppress wb_valid, and discard any later data_resultRDY.
REQ-030 flush in DONE SHALL suppress wb_valid; flush and in_valid together in IDLE SHALL issue nothing.
REQ-031 data_resultRDY in IDLE or DONE SHALL be ignored.
REQ-032 A new in_valid in DONE SHALL NOT be accepted; it is taken in the following IDLE cycle.
REQ-033 Timeout counter SHALL be 7 bits, saturating, no wrap.

Reset
REQ-034 reset SHALL asynchronously force IDLE; ctrl_MULT, ctrl_DIV, stall, wb_valid, wb_exception=0; wb_data, wb_rd, data_operandA, data_operandB, counter=0.
REQ-035 reset mid-WAIT SHALL drop the operation with no wb_valid; the next issue proceeds normally.

Structure
REQ-036 FSM state encoding and TIMEOUT default SHALL live in shared package multdiv_pkg.
REQ-037 Timeout counter SHALL be sub-module md_timeout_counter (clear, enable, saturate, terminal-count flag).

Verification
REQ-038 mult 7 x -3, RDY 33 cycles after pulse -> one ctrl_MULT pulse, wb_valid once, wb_data=0xFFFFFFEB, wb_exception=0, stall low same cycle.
REQ-039 div 100 / 0, unit exception=1 -> one ctrl_DIV pulse, wb_data=0, wb_exception=1.
REQ-040 RDY held high during ISSUE and first WAIT cycle, real RDY 31 cycles later -> capture only the later result.
REQ-041 RDY never asserted -> wb_valid at TIMEOUT (64) cycles after issue, wb_exception=1, wb_data=0.
REQ-042 flush 10 cycles into WAIT, RDY later -> no wb_valid; next mult 2 x 3 returns 6.
REQ-043 reset pulsed mid-WAIT -> all outputs 0 immediately; subsequent op completes correctly.
